// File: rtl/ov_pkg.sv
// Shared definitions for the OV DVP capture front end.
//   ov_state_e : capture FSM states (wait for first vsync, in vsync, active video)
//   MODE_*     : pixel packing modes selected by pair_mode
//   *_DEFAULT  : default bus / counter widths
package ov_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_VS   = 2'd1,
        S_ACT  = 2'd2
    } ov_state_e;

    localparam logic MODE_BYTE = 1'b0;
    localparam logic MODE_PAIR = 1'b1;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned CW_DEFAULT = 16;

endpackage

// File: rtl/ov_sync_edge.sv
// Two-flop synchroniser with rise/fall detection on the synchronised value.
//   clk_sys, rst_n : system clock, async active-low reset
//   async_i        : asynchronous input bits
//   sync_o         : synchronised bits (2 flops)
//   rise_o/fall_o  : one-cycle edge strobes, valid alongside sync_o
module ov_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ov_capture_mon.sv
// DVP capture front end: oversamples the sensor pins in clk_sys, glitch-filters
// vsync, packs bytes into 1- or 2-byte pixels and tracks frame/line geometry.
//   clk_sys, rst_n               : system clock (>= 4x pclk), async active-low reset
//   ov_data/href/vsync/pclk      : asynchronous sensor pins
//   pair_mode                    : 0 one byte per pixel, 1 two bytes (first in MSBs)
//   clr_err                      : clears sticky error flags
//   pix_data/pix_vld/pix_sof     : pixel stream to the downstream FIFO
//   line_done/frame_done         : one-cycle event pulses
//   line_len/frame_lines/frame_cnt : geometry for the register block
//   err_len/err_odd              : sticky line-length / odd-byte-count errors
module ov_capture_mon
    import ov_pkg::*;
#(
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned CW      = CW_DEFAULT,
    parameter int unsigned VS_FILT = 8
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    input  logic [DW-1:0]   ov_data,
    input  logic            ov_href,
    input  logic            ov_vsync,
    input  logic            ov_pclk,
    input  logic            pair_mode,
    input  logic            clr_err,
    output logic [2*DW-1:0] pix_data,
    output logic            pix_vld,
    output logic            pix_sof,
    output logic            line_done,
    output logic [CW-1:0]   line_len,
    output logic [CW-1:0]   frame_lines,
    output logic [CW-1:0]   frame_cnt,
    output logic            frame_done,
    output logic            err_len,
    output logic            err_odd
);

    // Synchronised control pins and their edges
    logic pclk_s, pclk_rise, pclk_fall;
    logic href_s, href_rise, href_fall;
    logic vs_s, vs_srise, vs_sfall;
    logic unused_edges;

    ov_sync_edge #(.W(1)) u_sync_pclk (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .async_i (ov_pclk),
        .sync_o  (pclk_s),
        .rise_o  (pclk_rise),
        .fall_o  (pclk_fall)
    );

    ov_sync_edge #(.W(1)) u_sync_href (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .async_i (ov_href),
        .sync_o  (href_s),
        .rise_o  (href_rise),
        .fall_o  (href_fall)
    );

    ov_sync_edge #(.W(1)) u_sync_vs (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .async_i (ov_vsync),
        .sync_o  (vs_s),
        .rise_o  (vs_srise),
        .fall_o  (vs_sfall)
    );

    // vsync uses the filtered level, not the raw synchronised edges
    assign unused_edges = ^{pclk_s, pclk_fall, vs_srise, vs_sfall};

    ov_state_e          state_q, state_d;
    logic [DW-1:0]      data_meta_q, data_meta_d;
    logic [DW-1:0]      data_s_q, data_s_d;
    logic [VS_FILT-1:0] vs_shift_q, vs_shift_d;
    logic               vs_f_q, vs_f_d;
    logic               vs_rise, vs_fall;
    logic [CW-1:0]      line_cnt_q, line_cnt_d;
    logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
    logic               first_done_q, first_done_d;
    logic               pair_q, pair_d;
    logic               phase_q, phase_d;
    logic [DW-1:0]      hi_q, hi_d;
    logic               sof_pend_q, sof_pend_d;
    logic [2*DW-1:0]    pix_data_q, pix_data_d;
    logic               pix_vld_q, pix_vld_d;
    logic               pix_sof_q, pix_sof_d;
    logic               line_done_q, line_done_d;
    logic [CW-1:0]      line_len_q, line_len_d;
    logic [CW-1:0]      frame_lines_q, frame_lines_d;
    logic [CW-1:0]      frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               err_len_q, err_len_d;
    logic               err_odd_q, err_odd_d;
    logic               err_len_set, err_odd_set;
    logic               emit;
    logic [2*DW-1:0]    emit_data;

    always_comb begin
        state_d       = state_q;
        data_meta_d   = ov_data;
        data_s_d      = data_meta_q;
        vs_shift_d    = {vs_shift_q[VS_FILT-2:0], vs_s};
        line_cnt_d    = line_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        first_done_d  = first_done_q;
        pair_d        = pair_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        sof_pend_d    = sof_pend_q;
        pix_data_d    = pix_data_q;
        pix_vld_d     = 1'b0;
        pix_sof_d     = 1'b0;
        line_done_d   = 1'b0;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        frame_cnt_d   = frame_cnt_q;
        frame_done_d  = 1'b0;
        err_len_set   = 1'b0;
        err_odd_set   = 1'b0;
        emit          = 1'b0;
        emit_data     = '0;

        // Filtered vsync only moves on a full run of equal samples
        if (&vs_shift_q) begin
            vs_f_d = 1'b1;
        end else if (~|vs_shift_q) begin
            vs_f_d = 1'b0;
        end else begin
            vs_f_d = vs_f_q;
        end
        vs_rise = vs_f_d & ~vs_f_q;
        vs_fall = ~vs_f_d & vs_f_q;

        unique case (state_q)
            S_WAIT: begin
                if (vs_rise) begin
                    state_d = S_VS;
                end
            end
            S_VS: begin
                if (vs_fall) begin
                    state_d      = S_ACT;
                    line_cnt_d   = '0;
                    byte_cnt_d   = '0;
                    first_done_d = 1'b0;
                    pair_d       = pair_mode;
                    phase_d      = 1'b0;
                    sof_pend_d   = 1'b1;
                end
            end
            S_ACT: begin
                if (vs_rise) begin
                    // Any line still open is abandoned without line_done
                    state_d       = S_VS;
                    frame_lines_d = line_cnt_q;
                    frame_cnt_d   = frame_cnt_q + CW'(1);
                    frame_done_d  = 1'b1;
                end else begin
                    if (href_rise) begin
                        if (line_cnt_q != {CW{1'b1}}) begin
                            line_cnt_d = line_cnt_q + CW'(1);
                        end
                        byte_cnt_d = '0;
                        phase_d    = 1'b0;
                    end
                    if (href_fall) begin
                        line_done_d = 1'b1;
                        if (!first_done_q) begin
                            line_len_d   = byte_cnt_q;
                            first_done_d = 1'b1;
                        end else if (byte_cnt_q != line_len_q) begin
                            err_len_set = 1'b1;
                        end
                        if (pair_q == MODE_PAIR && byte_cnt_q[0]) begin
                            err_odd_set = 1'b1;
                        end
                    end
                    // href_s is already low on the falling-edge cycle, so a
                    // coincident pclk edge carries no byte
                    if (pclk_rise && href_s) begin
                        if (byte_cnt_d != {CW{1'b1}}) begin
                            byte_cnt_d = byte_cnt_d + CW'(1);
                        end
                        if (pair_q == MODE_BYTE) begin
                            emit      = 1'b1;
                            emit_data = {{DW{1'b0}}, data_s_q};
                        end else if (!phase_d) begin
                            hi_d    = data_s_q;
                            phase_d = 1'b1;
                        end else begin
                            emit      = 1'b1;
                            emit_data = {hi_q, data_s_q};
                            phase_d   = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_WAIT;
        endcase

        if (emit) begin
            pix_vld_d  = 1'b1;
            pix_data_d = emit_data;
            pix_sof_d  = sof_pend_q;
            sof_pend_d = 1'b0;
        end

        // A new error wins over a same-cycle clear
        err_len_d = (clr_err ? 1'b0 : err_len_q) | err_len_set;
        err_odd_d = (clr_err ? 1'b0 : err_odd_q) | err_odd_set;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_WAIT;
            data_meta_q   <= '0;
            data_s_q      <= '0;
            vs_shift_q    <= '0;
            vs_f_q        <= 1'b0;
            line_cnt_q    <= '0;
            byte_cnt_q    <= '0;
            first_done_q  <= 1'b0;
            pair_q        <= MODE_BYTE;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            sof_pend_q    <= 1'b0;
            pix_data_q    <= '0;
            pix_vld_q     <= 1'b0;
            pix_sof_q     <= 1'b0;
            line_done_q   <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_cnt_q   <= '0;
            frame_done_q  <= 1'b0;
            err_len_q     <= 1'b0;
            err_odd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_meta_q   <= data_meta_d;
            data_s_q      <= data_s_d;
            vs_shift_q    <= vs_shift_d;
            vs_f_q        <= vs_f_d;
            line_cnt_q    <= line_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            first_done_q  <= first_done_d;
            pair_q        <= pair_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            sof_pend_q    <= sof_pend_d;
            pix_data_q    <= pix_data_d;
            pix_vld_q     <= pix_vld_d;
            pix_sof_q     <= pix_sof_d;
            line_done_q   <= line_done_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_done_q  <= frame_done_d;
            err_len_q     <= err_len_d;
            err_odd_q     <= err_odd_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_vld     = pix_vld_q;
    assign pix_sof     = pix_sof_q;
    assign line_done   = line_done_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_done  = frame_done_q;
    assign err_len     = err_len_q;
    assign err_odd     = err_odd_q;

endmodule

// File: tb/tb_ov_capture_mon.sv
// Directed bench for ov_capture_mon: drives DVP pin sequences at pclk = clk_sys/4
// and compares the pixel stream, event counts and geometry with hand values.
module tb_ov_capture_mon;

    localparam int DW      = 8;
    localparam int CW      = 16;
    localparam int VS_FILT = 8;

    logic            clk_sys = 1'b0;
    logic            rst_n   = 1'b0;
    logic [DW-1:0]   ov_data = '0;
    logic            ov_href = 1'b0;
    logic            ov_vsync = 1'b0;
    logic            ov_pclk = 1'b0;
    logic            pair_mode = 1'b0;
    logic            clr_err = 1'b0;
    logic [2*DW-1:0] pix_data;
    logic            pix_vld;
    logic            pix_sof;
    logic            line_done;
    logic [CW-1:0]   line_len;
    logic [CW-1:0]   frame_lines;
    logic [CW-1:0]   frame_cnt;
    logic            frame_done;
    logic            err_len;
    logic            err_odd;

    ov_capture_mon #(
        .DW      (DW),
        .CW      (CW),
        .VS_FILT (VS_FILT)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .ov_data     (ov_data),
        .ov_href     (ov_href),
        .ov_vsync    (ov_vsync),
        .ov_pclk     (ov_pclk),
        .pair_mode   (pair_mode),
        .clr_err     (clr_err),
        .pix_data    (pix_data),
        .pix_vld     (pix_vld),
        .pix_sof     (pix_sof),
        .line_done   (line_done),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .frame_cnt   (frame_cnt),
        .frame_done  (frame_done),
        .err_len     (err_len),
        .err_odd     (err_odd)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    logic [15:0] pix_log[$];
    int pix_n = 0;
    int sof_n = 0;
    int sof_at = -1;
    int stray_sof = 0;
    int line_n = 0;
    int frame_n = 0;

    always @(negedge clk_sys) begin
        if (pix_vld) begin
            pix_log.push_back(pix_data);
            if (pix_sof) begin
                sof_n  <= sof_n + 1;
                sof_at <= pix_n;
            end
            pix_n <= pix_n + 1;
        end else if (pix_sof) begin
            stray_sof <= stray_sof + 1;
        end
        if (line_done) line_n <= line_n + 1;
        if (frame_done) frame_n <= frame_n + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ov_data = b;
        ov_pclk = 1'b0;
        wait_clk(2);
        ov_pclk = 1'b1;
        wait_clk(2);
        ov_pclk = 1'b0;
    endtask

    // clr_at_end pulses clr_err in exactly the cycle href_s falling is seen
    task automatic send_line(input int n, input logic [7:0] first, input int step,
                             input bit clr_at_end);
        ov_href = 1'b1;
        wait_clk(2);
        for (int i = 0; i < n; i++) send_byte(first + 8'(step * i));
        ov_href = 1'b0;
        if (clr_at_end) begin
            wait_clk(2);
            clr_err = 1'b1;
            wait_clk(1);
            clr_err = 1'b0;
            wait_clk(9);
        end else begin
            wait_clk(12);
        end
    endtask

    task automatic vs_pulse();
        ov_vsync = 1'b1;
        wait_clk(24);
        ov_vsync = 1'b0;
        wait_clk(24);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int fn;
        int ln;
        int pn;
        logic [15:0] exp_pair [4];
        exp_pair[0] = 16'h1122;
        exp_pair[1] = 16'h3344;
        exp_pair[2] = 16'h5566;
        exp_pair[3] = 16'h7788;

        // Reset state
        wait_clk(3);
        check_val("rst_pix_data", 32'(pix_data), 32'h0);
        check_val("rst_strobes", 32'({pix_vld, pix_sof, line_done, frame_done}), 32'h0);
        check_val("rst_geom", 32'({line_len, frame_lines}), 32'h0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check_val("rst_err", 32'({err_len, err_odd}), 32'h0);
        rst_n = 1'b1;
        wait_clk(3);

        // A line before any vsync is ignored
        send_line(10, 8'h20, 1, 1'b0);
        check_val("pre_vs_pix", 32'(pix_n), 32'd0);
        check_val("pre_vs_lines", 32'(line_n), 32'd0);

        // Byte mode: 3 frames of 4 lines x 10 bytes
        pair_mode = 1'b0;
        vs_pulse();
        for (int f = 0; f < 3; f++) begin
            base = pix_n;
            for (int l = 0; l < 4; l++) send_line(10, 8'(32 + 16 * l), 1, 1'b0);
            vs_pulse();
            check_val("byte_frame_cnt", 32'(frame_cnt), 32'(f + 1));
            check_val("byte_pix_count", 32'(pix_n - base), 32'd40);
            check_val("byte_first_pix", 32'(pix_log[base]), 32'h0020);
            check_val("byte_last_pix", 32'(pix_log[base + 39]), 32'h0059);
            check_val("byte_sof_pos", 32'(sof_at), 32'(base));
        end
        check_val("byte_sof_n", 32'(sof_n), 32'd3);
        check_val("byte_line_n", 32'(line_n), 32'd12);
        check_val("byte_frame_n", 32'(frame_n), 32'd3);
        check_val("byte_line_len", 32'(line_len), 32'd10);
        check_val("byte_frame_lines", 32'(frame_lines), 32'd4);
        check_val("byte_err", 32'({err_len, err_odd}), 32'h0);

        // Pair mode: 2 lines of 0x11..0x88
        pair_mode = 1'b1;
        vs_pulse();
        check_val("empty_frame_lines", 32'(frame_lines), 32'd0);
        base = pix_n;
        send_line(8, 8'h11, 17, 1'b0);
        send_line(8, 8'h11, 17, 1'b0);
        check_val("pair_pix_count", 32'(pix_n - base), 32'd8);
        for (int k = 0; k < 4; k++) begin
            check_val("pair_pix", 32'(pix_log[base + k]), 32'(exp_pair[k]));
        end
        check_val("pair_pix_l2", 32'(pix_log[base + 4]), 32'h1122);
        check_val("pair_line_len", 32'(line_len), 32'd8);
        check_val("pair_err_odd_clean", 32'(err_odd), 32'h0);
        vs_pulse();
        check_val("pair_frame_lines", 32'(frame_lines), 32'd2);
        check_val("pair_frame_cnt", 32'(frame_cnt), 32'd5);

        // Pair mode odd line: dangling byte dropped, err_odd sticky
        base = pix_n;
        send_line(7, 8'h01, 1, 1'b0);
        check_val("odd_pix_count", 32'(pix_n - base), 32'd3);
        check_val("odd_last_pix", 32'(pix_log[base + 2]), 32'h0506);
        check_val("odd_line_len", 32'(line_len), 32'd7);
        check_val("odd_err_odd", 32'(err_odd), 32'h1);
        pair_mode = 1'b0;
        vs_pulse();
        check_val("odd_err_hold", 32'(err_odd), 32'h1);
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        wait_clk(2);
        check_val("odd_err_clr", 32'(err_odd), 32'h0);

        // Byte mode length error, set coinciding with clr_err
        send_line(8, 8'h40, 1, 1'b0);
        send_line(9, 8'h50, 1, 1'b1);
        check_val("len_err_vs_clr", 32'(err_len), 32'h1);
        check_val("len_no_odd_byte", 32'(err_odd), 32'h0);
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        wait_clk(2);
        check_val("len_err_clr", 32'(err_len), 32'h0);

        // Short vsync glitch in active video is filtered out
        fn = frame_n;
        ov_vsync = 1'b1;
        wait_clk(VS_FILT - 1);
        ov_vsync = 1'b0;
        wait_clk(20);
        check_val("glitch_no_frame", 32'(frame_n), 32'(fn));
        ln = line_n;
        send_line(8, 8'h60, 1, 1'b0);
        check_val("glitch_still_act", 32'(line_n), 32'(ln + 1));
        check_val("glitch_len_ok", 32'(err_len), 32'h0);
        vs_pulse();
        check_val("glitch_frame_lines", 32'(frame_lines), 32'd3);
        check_val("glitch_frame_cnt", 32'(frame_cnt), 32'd7);

        // Reset mid-line
        ov_href = 1'b1;
        wait_clk(2);
        send_byte(8'h70);
        send_byte(8'h71);
        send_byte(8'h72);
        rst_n = 1'b0;
        wait_clk(2);
        check_val("mid_rst_cnt", 32'(frame_cnt), 32'h0);
        check_val("mid_rst_geom", 32'({line_len, frame_lines}), 32'h0);
        check_val("mid_rst_out", 32'({pix_data, pix_vld, pix_sof, line_done, err_len, err_odd}),
                  32'h0);
        rst_n = 1'b1;
        ov_href = 1'b0;
        wait_clk(12);
        pn = pix_n;
        ln = line_n;
        send_line(6, 8'h80, 1, 1'b0);
        send_line(6, 8'h80, 1, 1'b0);
        check_val("post_rst_ignored_pix", 32'(pix_n), 32'(pn));
        check_val("post_rst_ignored_ln", 32'(line_n), 32'(ln));
        fn = frame_n;
        vs_pulse();
        check_val("post_rst_no_done", 32'(frame_n), 32'(fn));
        check_val("post_rst_cnt0", 32'(frame_cnt), 32'h0);
        send_line(5, 8'h90, 1, 1'b0);
        send_line(5, 8'h90, 1, 1'b0);
        check_val("resume_pix", 32'(pix_n - pn), 32'd10);
        vs_pulse();
        check_val("resume_frame_cnt", 32'(frame_cnt), 32'd1);
        check_val("resume_frame_lines", 32'(frame_lines), 32'd2);
        check_val("resume_line_len", 32'(line_len), 32'd5);
        check_val("stray_sof", 32'(stray_sof), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
